serial_add_sched: RTL and testbench

//   Shares one single-bit full-adder cell among N requesters. Each requester gets a
//   bit-serial WIDTH-bit add: LSB first, one bit per clock, with a carry flop.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_sched_fa_cell.sv | 13 +
 rtl/serial_add_sched.sv | 178 +++++++++++++++++
 tb/tb_serial_add_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add scheduler.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   // Index width for n items; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_add_sched_fa_cell.sv
// One-bit full adder: the single arithmetic resource shared by all requesters.
module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler feeding N requesters through one bit-serial adder.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow output `ovf`.
module serial_add_sched
   import serial_add_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [N*WIDTH-1:0]     a_in,
   input  logic [N*WIDTH-1:0]     b_in,
   output logic [N-1:0]           gnt,
   output logic                   busy,
   output logic                   done,
   output logic [id_w(N)-1:0]     done_id,
   output logic [WIDTH-1:0]       sum,
   output logic                   cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic                   ovf
`endif
);

   localparam int ID_W = id_w(N);
   localparam int CW   = id_w(WIDTH);

   sa_state_e        state_q, state_d;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic [ID_W-1:0]  win_q, win_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] shs_q, shs_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [ID_W-1:0]  did_q, did_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             cmsb_q, cmsb_d;
   logic             ovf_q, ovf_d;
`endif

   logic             fa_s, fa_co;
   logic             arb_any;
   logic [ID_W-1:0]  arb_w;

   fa_cell u_fa (
      .a_i  (sha_q[0]),
      .b_i  (shb_q[0]),
      .c_i  (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // Rotating priority: descend so the last hit is the one closest to rr_q.
   always_comb begin
      logic [ID_W-1:0] idx;
      arb_any = 1'b0;
      arb_w   = '0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_q) + k) % N);
         if (req[idx]) begin
            arb_any = 1'b1;
            arb_w   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      shs_d   = shs_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      did_d   = did_q;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_d  = cmsb_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d = RUN;
               win_d   = arb_w;
               sha_d   = a_in[arb_w*WIDTH +: WIDTH];
               shb_d   = b_in[arb_w*WIDTH +: WIDTH];
               carry_d = 1'b0;
               cnt_d   = '0;
               gnt_d   = N'(1) << arb_w;
               rr_d    = ID_W'((int'(arb_w) + 1) % N);
            end
         end
         RUN: begin
            shs_d   = {fa_s, shs_q[WIDTH-1:1]};
            sha_d   = {1'b0, sha_q[WIDTH-1:1]};
            shb_d   = {1'b0, shb_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
               cmsb_d  = carry_q;
`endif
            end
         end
         DONE: begin
            // Results become the held values once the done cycle ends.
            state_d = IDLE;
            sum_d   = shs_q;
            cout_d  = carry_q;
            did_d   = win_q;
`ifdef SERIAL_ADD_OVF_EN
            ovf_d   = cmsb_q ^ carry_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         win_q   <= '0;
         sha_q   <= '0;
         shb_q   <= '0;
         shs_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         did_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         cmsb_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         shs_q   <= shs_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         did_q   <= did_d;
`ifdef SERIAL_ADD_OVF_EN
         cmsb_q  <= cmsb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign busy    = (state_q == RUN) || (state_q == DONE);
   assign done    = (state_q == DONE);
   assign sum     = done ? shs_q   : sum_q;
   assign cout    = done ? carry_q : cout_q;
   assign done_id = done ? win_q   : did_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf     = done ? (cmsb_q ^ carry_q) : ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: transaction-level model plus directed scenarios.
module tb_serial_add_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   a_in = '0;
   logic [N*W-1:0]   b_in = '0;
   logic [N-1:0]     gnt;
   logic             busy, done, cout;
   logic [1:0]       done_id;
   logic [W-1:0]     sum;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   serial_add_sched #(.N(N), .WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .a_in    (a_in),
      .b_in    (b_in),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .sum     (sum),
      .cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: t counts remaining busy cycles (W RUN + 1 DONE).
   int mt, m_rr, m_w, m_pend, m_povf;
   int e_sum, e_cout, e_ovf, e_id;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mt = 0; m_rr = 0; m_w = 0; m_pend = 0; m_povf = 0;
         e_sum = 0; e_cout = 0; e_ovf = 0; e_id = 0;
      end else if (mt > 0) begin
         mt = mt - 1;
         if (mt == 1) begin
            e_sum  = m_pend % (1 << W);
            e_cout = (m_pend >> W) & 1;
            e_ovf  = m_povf;
            e_id   = m_w;
         end
      end else if (req != 0) begin
         int wsel, av, bv, cm;
         wsel = -1;
         for (int k = 0; k < N; k++)
            if (wsel < 0 && req[(m_rr + k) % N]) wsel = (m_rr + k) % N;
         av     = int'(a_in[wsel*W +: W]);
         bv     = int'(b_in[wsel*W +: W]);
         m_pend = av + bv;
         cm     = ((av % (1 << (W-1))) + (bv % (1 << (W-1)))) >> (W-1);
         m_povf = cm ^ ((m_pend >> W) & 1);
         m_w    = wsel;
         m_rr   = (wsel + 1) % N;
         mt     = W + 1;
      end
   end

   always @(posedge clk) begin
      #2;
      check("gnt",  gnt,  (mt == W + 1) ? (32'd1 << m_w) : 32'd0);
      check("busy", busy, (mt > 0) ? 32'd1 : 32'd0);
      check("done", done, (mt == 1) ? 32'd1 : 32'd0);
      check("sum",  sum,  e_sum);
      check("cout", cout, e_cout);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf",  ovf,  e_ovf);
`endif
      if (mt == 1) check("done_id", done_id, e_id);
   end

   function automatic int oh_idx(input logic [N-1:0] v);
      int r = -1;
      for (int k = 0; k < N; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", busy, 0);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic start_add(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [N-1:0] one;
      wait_idle();
      one = '0;
      one[i] = 1'b1;
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
      req = one;
      @(negedge clk);
      check("gnt_onehot", gnt, one);
      req = '0;
   endtask

   initial begin
      int n, ng, nd;
      int order[5];
      int dcyc[5];

      // 1: reset, then quiet for 20 cycles
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t1_busy", busy, 0);
      check("t1_gnt", gnt, 0);

      // 2: basic add, latency from grant to done
      start_add(1, 8'h5A, 8'h3C);
      wait_done(n);
      check("t2_lat", n, 8);
      check("t2_sum", sum, 8'h96);
      check("t2_cout", cout, 0);
      check("t2_id", done_id, 1);

      // 3: full carry out, then signed overflow case
      start_add(2, 8'hFF, 8'h01);
      wait_done(n);
      check("t3_sum", sum, 8'h00);
      check("t3_cout", cout, 1);
      start_add(2, 8'h7F, 8'h01);
      wait_done(n);
      check("t3b_sum", sum, 8'h80);
      check("t3b_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("t3b_ovf", ovf, 1);
`endif

      // 5: operand changes after grant must not disturb the add
      start_add(3, 8'h12, 8'h34);
      a_in[3*W +: W] = 8'hFF;
      b_in[3*W +: W] = 8'hFF;
      wait_done(n);
      check("t5_sum", sum, 8'h46);
      check("t5_id", done_id, 3);

      // 4: all requesters held, rotation and done spacing
      wait_idle();
      a_in = {8'h80, 8'h21, 8'hC3, 8'h07};
      b_in = {8'h80, 8'h10, 8'h5D, 8'hF9};
      req  = '1;
      ng = 0; nd = 0;
      for (int c = 0; c < 100 && nd < 5; c++) begin
         @(negedge clk);
         if (gnt != 0 && ng < 5) begin
            order[ng] = oh_idx(gnt);
            ng++;
         end
         if (done) begin
            dcyc[nd] = c;
            nd++;
         end
      end
      req = '0;
      check("t4_ndone", nd, 5);
      check("t4_ngnt", ng, 5);
      for (int k = 0; k < 5; k++) check("t4_order", order[k], k % N);
      for (int k = 0; k < 4; k++) check("t4_spacing", dcyc[k+1] - dcyc[k], 10);

      // 6: reset in the 4th RUN cycle aborts; pointer restarts at 0
      start_add(2, 8'h55, 8'h0F);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_sum", sum, 0);
      check("t6_gnt", gnt, 0);
      check("t6_id", done_id, 0);
      @(negedge clk);
      rst = 1'b0;
      a_in[0 +: W] = 8'h01;
      b_in[0 +: W] = 8'h02;
      req = 4'b1001;
      @(negedge clk);
      check("t6_regnt", gnt, 4'b0001);
      req = '0;
      wait_done(n);
      check("t6_reid", done_id, 0);
      check("t6_resum", sum, 8'h03);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
